// File: rtl/rr_mux_slice.sv
// rr_mux_slice: N-input valid/ready arbiter feeding one registered output slot.
//
// Chooses one of N_INPUTS producer streams each cycle, either round-robin
// (RR_MODE=1) or fixed priority with the lowest index winning (RR_MODE=0).
// The chosen word goes into a single output register. Throughput is one word
// per cycle, and latency is one cycle.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_data    packed input words; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   per-channel word-present flags
//   in_ready   per-channel accept strobes, one-hot or zero
//   out_data   registered selected word
//   out_sel    registered index of the channel that supplied out_data
//   out_valid  output slot holds a word
//   out_ready  consumer accepts out_data this cycle
//
// Handshake: a word moves across an interface on every rising edge where
// valid && ready are both high. The producer keeps valid high until that
// edge. in_ready is derived combinationally from in_valid and out_ready, so a
// producer must never make in_valid depend on in_ready.
module rr_mux_slice #(
    parameter int  DATA_WIDTH = 8,
    parameter int  N_INPUTS   = 4,
    parameter int  RR_MODE    = 1,
    localparam int SEL_W      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_INPUTS*DATA_WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]            in_valid,
    output logic [N_INPUTS-1:0]            in_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]               out_sel,
    output logic                           out_valid,
    input  logic                           out_ready
);

    logic [DATA_WIDTH-1:0] words [N_INPUTS];
    logic [SEL_W-1:0]      ptr;
    logic [SEL_W-1:0]      gnt_idx;
    logic [SEL_W-1:0]      ptr_next;
    logic                  gnt_found;
    logic                  load;
    logic                  xfer;

    for (genvar i = 0; i < N_INPUTS; i++) begin : g_unpack
        assign words[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // The slot can take a new word when it is empty, or when it drains in
    // this same cycle. Refilling a draining slot is what gives full rate.
    assign load = !out_valid || out_ready;

    // Scan the channels in priority order and keep the first valid one. In
    // round-robin mode the scan starts at ptr and wraps. In fixed mode it
    // starts at channel 0.
    always_comb begin
        logic [SEL_W-1:0] idx;
        idx       = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < N_INPUTS; k++) begin
            if (RR_MODE != 0) begin
                idx = SEL_W'((int'(ptr) + k) % N_INPUTS);
            end else begin
                idx = SEL_W'(k);
            end
            if (!gnt_found && in_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
    end

    assign xfer = rst_n && load && gnt_found;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // The pointer moves to just past the channel that won, so that channel
    // has the lowest priority on the next scan.
    assign ptr_next = (gnt_idx == SEL_W'(N_INPUTS - 1)) ? '0 : gnt_idx + SEL_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= words[gnt_idx];
            out_sel   <= gnt_idx;
            if (RR_MODE != 0) begin
                ptr <= ptr_next;
            end
        end else if (load) begin
            // The slot drained (or was already empty) and nothing refilled it.
            // out_data and out_sel keep their last values.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_mux_slice.sv
// Bench for rr_mux_slice. A round-robin instance and a fixed-priority
// instance share one set of stimulus. A reference model and a word scoreboard
// check both instances on every cycle. Directed sections check the
// rotation, skip/wrap, back-pressure, priority, drain and reset cases. After
// those, a randomized run is applied.
module tb_rr_mux_slice;

    localparam int DW = 8;
    localparam int N  = 4;

    logic            clk;
    logic            rst_n;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic            out_ready;

    logic [N-1:0]  rr_in_ready,  fp_in_ready;
    logic [DW-1:0] rr_out_data,  fp_out_data;
    logic [1:0]    rr_out_sel,   fp_out_sel;
    logic          rr_out_valid, fp_out_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Model state, indexed by mode: [1] = round-robin, [0] = fixed priority.
    logic          m_valid [2];
    logic [DW-1:0] m_data  [2];
    int            m_sel   [2];
    int            m_ptr   [2];
    logic [DW-1:0] exp_q_rr[$];
    logic [DW-1:0] exp_q_fp[$];

    logic [N-1:0] last_rdy_rr, last_rdy_fp;

    rr_mux_slice #(.DATA_WIDTH(DW), .N_INPUTS(N), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
        .out_valid(rr_out_valid), .out_ready(out_ready)
    );

    rr_mux_slice #(.DATA_WIDTH(DW), .N_INPUTS(N), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(fp_in_ready), .out_data(fp_out_data), .out_sel(fp_out_sel),
        .out_valid(fp_out_valid), .out_ready(out_ready)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Returns the granted channel from the arbitration rule, or -1 if no
    // channel is valid.
    function automatic int pick(input int rr, input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (rr != 0) ? (p + k) % N : k;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // Compares one instance with the model for the current cycle. Then it
    // advances the model to the state it will have after the next edge.
    task automatic model_step(input int m, input string pfx, input logic [N-1:0] rdy,
                              input logic v, input logic [DW-1:0] d, input logic [1:0] s);
        int            g;
        logic          ld;
        logic [N-1:0]  er;
        logic [DW-1:0] w;
        ld = !m_valid[m] || out_ready;
        g  = pick(m, in_valid, m_ptr[m]);
        er = '0;
        if (rst_n && ld && g >= 0) er[g] = 1'b1;
        check({pfx, "in_ready"},  rdy, er);
        check({pfx, "out_valid"}, v,   m_valid[m]);
        check({pfx, "out_data"},  d,   m_data[m]);
        check({pfx, "out_sel"},   s,   m_sel[m]);

        // Scoreboard: each output transfer must match the oldest accepted word.
        if (rst_n && m_valid[m] && out_ready) begin
            if (m == 1) begin
                if (exp_q_rr.size() == 0) check({pfx, "sb_underflow"}, 1, 0);
                else begin w = exp_q_rr.pop_front(); check({pfx, "sb_word"}, d, w); end
            end else begin
                if (exp_q_fp.size() == 0) check({pfx, "sb_underflow"}, 1, 0);
                else begin w = exp_q_fp.pop_front(); check({pfx, "sb_word"}, d, w); end
            end
        end

        if (!rst_n) begin
            m_valid[m] = 1'b0;
            m_data[m]  = '0;
            m_sel[m]   = 0;
            m_ptr[m]   = 0;
            if (m == 1) exp_q_rr.delete(); else exp_q_fp.delete();
        end else if (ld && g >= 0) begin
            w = in_data[g*DW +: DW];
            if (m == 1) exp_q_rr.push_back(w); else exp_q_fp.push_back(w);
            m_valid[m] = 1'b1;
            m_data[m]  = w;
            m_sel[m]   = g;
            if (m == 1) m_ptr[m] = (g + 1) % N;
        end else if (ld) begin
            m_valid[m] = 1'b0;
        end
    endtask

    // Driver: applies the inputs for one cycle and checks both instances
    // at the falling edge. It returns 1 time unit after the next rising edge.
    task automatic cycle(input logic r, input logic [N-1:0] v, input logic rdy);
        rst_n     = r;
        in_valid  = v;
        out_ready = rdy;
        @(negedge clk);
        model_step(1, "rr_", rr_in_ready, rr_out_valid, rr_out_data, rr_out_sel);
        model_step(0, "fp_", fp_in_ready, fp_out_valid, fp_out_data, fp_out_sel);
        last_rdy_rr = rr_in_ready;
        last_rdy_fp = fp_in_ready;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            m_valid[m] = 1'b0;
            m_data[m]  = '0;
            m_sel[m]   = 0;
            m_ptr[m]   = 0;
        end
        rst_n     = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        in_data   = 32'hA3A2A1A0;
        @(posedge clk);
        #1;

        // Reset held with every channel requesting
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 4'b1111, 1'b1);
            check("rst_in_ready", last_rdy_rr, 4'b0000);
            check("rst_out_valid", rr_out_valid, 1'b0);
            check("rst_out_data", rr_out_data, 8'h00);
            check("rst_out_sel", rr_out_sel, 2'd0);
        end

        // Round-robin rotation with all channels valid
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 4'b1111, 1'b1);
            if (k == 0) check("first_grant", last_rdy_rr, 4'b0001);
            check("rot_sel", rr_out_sel, k % 4);
            check("rot_data", rr_out_data, 8'hA0 + k % 4);
            check("rot_valid", rr_out_valid, 1'b1);
        end

        // Skip and wrap: the last grant was channel 1
        cycle(1'b1, 4'b0001, 1'b1);
        check("wrap_rdy", last_rdy_rr, 4'b0001);
        check("wrap_sel", rr_out_sel, 2'd0);
        cycle(1'b1, 4'b1001, 1'b1);
        check("skip_rdy", last_rdy_rr, 4'b1000);
        check("skip_sel", rr_out_sel, 2'd3);

        // Back-pressure while the slot holds channel 2's word
        cycle(1'b1, 4'b0100, 1'b1);
        check("bp_load_sel", rr_out_sel, 2'd2);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 4'b1111, 1'b0);
            check("bp_in_ready", last_rdy_rr, 4'b0000);
            check("bp_data", rr_out_data, 8'hA2);
            check("bp_sel", rr_out_sel, 2'd2);
            check("bp_valid", rr_out_valid, 1'b1);
        end
        cycle(1'b1, 4'b1111, 1'b1);
        check("bp_release_rdy", last_rdy_rr, 4'b1000);
        check("bp_release_sel", rr_out_sel, 2'd3);
        check("bp_release_data", rr_out_data, 8'hA3);
        check("bp_release_valid", rr_out_valid, 1'b1);

        // Fixed priority: channel 1 is always granted
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 4'b1110, 1'b1);
            check("fp_rdy", last_rdy_fp, 4'b0010);
            check("fp_sel", fp_out_sel, 2'd1);
            check("fp_data", fp_out_data, 8'hA1);
        end

        // Drain: no new input, so the slot empties
        cycle(1'b1, 4'b0000, 1'b1);
        check("drain_rr_valid", rr_out_valid, 1'b0);
        check("drain_fp_valid", fp_out_valid, 1'b0);

        // Reset while a word is stalled in the slot
        cycle(1'b1, 4'b1111, 1'b1);
        cycle(1'b1, 4'b1111, 1'b0);
        check("hold_before_rst", rr_out_valid, 1'b1);
        cycle(1'b0, 4'b1111, 1'b0);
        check("midrst_valid", rr_out_valid, 1'b0);
        check("midrst_rdy", last_rdy_rr, 4'b0000);
        cycle(1'b1, 4'b1111, 1'b1);
        check("midrst_ptr_restart", last_rdy_rr, 4'b0001);
        check("midrst_sel", rr_out_sel, 2'd0);

        // Randomized traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            in_data = $urandom;
            cycle(($urandom_range(0, 49) != 0), 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) != 0));
        end

        // Final drain. Every accepted word must have been delivered.
        cycle(1'b1, 4'b0000, 1'b1);
        cycle(1'b1, 4'b0000, 1'b1);
        check("rr_q_empty", exp_q_rr.size(), 0);
        check("fp_q_empty", exp_q_fp.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_slice.md
Name: rr_mux_slice

Overview:
- N-channel, parametrised successor of the 2:1 binary mux.
- Selects one of N_INPUTS valid/ready input streams and forwards its word through a single registered output slot.
- Selection is round-robin or fixed-priority, chosen by parameter.
- Sits between multiple producers and one shared consumer. Sustains one word per cycle with one cycle of latency.

Parameters:
- DATA_WIDTH, 8, width of every data word.
- N_INPUTS, 4, number of input channels, >= 1.
- RR_MODE, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins).
- SEL_W, max(1, $clog2(N_INPUTS)), derived width of channel index; not overridden.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- in_data  input  N_INPUTS*DATA_WIDTH  packed input words; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  N_INPUTS  per-channel word-present flag.
- in_ready  output  N_INPUTS  per-channel accept strobe, one-hot or zero.
- out_data  output  DATA_WIDTH  registered selected word.
- out_sel  output  SEL_W  registered index of the channel that supplied out_data.
- out_valid  output  1  output slot holds a word.
- out_ready  input  1  consumer accepts the output word this cycle.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, out_data=0, out_sel=0, round-robin pointer ptr=0.
  - in_ready is all-zero while rst_n=0.
  - Reset mid-operation discards any held word, with no transfer.
- Slot load enable: load = !out_valid || out_ready. The slot is refilled in the same cycle it drains, giving full throughput.
- Grant, combinational:
  - Valid only when load=1 and |in_valid.
  - RR_MODE=1: grant g = first index with in_valid set, scanning ptr, ptr+1, ..., wrapping modulo N_INPUTS.
  - RR_MODE=0: g = lowest set index of in_valid.
- in_ready[g]=1 only for the granted channel when load=1; all other bits 0.
- in_ready may depend combinationally on in_valid and out_ready. Producers must not make in_valid depend on in_ready.
- Input transfer: in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= word i
  - out_sel <= i
  - out_valid <= 1
  - RR_MODE=1: ptr <= (i+1) mod N_INPUTS; wraps from N_INPUTS-1 to 0.
- Output transfer with no new input transfer (out_valid && out_ready && no grant): out_valid <= 0.
  - out_data and out_sel hold their last values.
- Stall (out_valid && !out_ready):
  - in_ready all-zero.
  - out_data, out_sel and out_valid held stable.
  - ptr unchanged.
- ptr advances only on an input transfer, never on idle cycles.
- Fairness (RR_MODE=1): with all N_INPUTS channels continuously valid, each channel is granted exactly once in every N_INPUTS consecutive input transfers.
- N_INPUTS=1: channel 0 always granted when valid; out_sel constant 0; design degenerates to a one-entry pipeline register.
- Latency: word accepted at edge k appears on out_data/out_valid after edge k.
- No word is dropped or duplicated. Each input transfer produces exactly one output transfer.
- Input words are not required to stay stable before acceptance; the block samples only on the transfer cycle.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 3 cycles with in_valid=4'b1111 and out_ready=1.
  - Required: out_valid=0, out_data=0, out_sel=0, in_ready=0 throughout. First post-reset grant is channel 0.
- Round-robin rotation:
  - Stimulus: N_INPUTS=4, RR_MODE=1, in_valid=4'b1111 constant, out_ready=1; channel i drives word 8'hA0+i.
  - Required: out_sel sequence 0,1,2,3,0,1 with out_data A0,A1,A2,A3,A0,A1, one word per cycle, out_valid continuously 1.
- Skip and wrap:
  - Stimulus: after a grant of channel 1, set in_valid=4'b0001.
  - Required: channel 0 is granted (scan 2,3 then wraps to 0); ptr becomes 1.
  - Stimulus: then in_valid=4'b1001.
  - Required: channel 3 is granted.
- Back-pressure:
  - Stimulus: out_valid=1 holding 8'hA2 from channel 2; drive out_ready=0 for 5 cycles.
  - Required: in_ready=0, out_data=8'hA2, out_sel=2 stable throughout.
  - Stimulus: out_ready=1.
  - Required: channel 3's word arrives the next cycle with no gap.
- Fixed priority:
  - Stimulus: RR_MODE=0, in_valid=4'b1110 constant, out_ready=1.
  - Required: channel 1 granted every cycle; channels 2 and 3 never get in_ready.
- Drain and reset mid-operation:
  - Stimulus: out_valid=1, in_valid=0, out_ready=1.
  - Required: out_valid drops to 0 the next cycle.
  - Stimulus: in a separate run, assert rst_n=0 while out_valid=1 and out_ready=0.
  - Required: the held word is discarded, out_valid=0 after the edge, and ptr restarts at 0.
